// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deserializes start/data/even-parity/stop frames from a
// registered serial line, qualified by a bit strobe. Delivers each correctly
// framed word with a one-cycle VALID pulse and a held parity-error flag;
// a bad stop bit raises a one-cycle FERR and the line must return high
// before a new start bit is accepted.
module serial_frame_rx #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         CK,
    input  logic         RN,
    input  logic         DIN,
    input  logic         EN,
    output logic [W-1:0] DOUT,
    output logic         VALID,
    output logic         PERR,
    output logic         FERR,
    output logic         BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shreg;
    logic [CW-1:0]   r_cnt;
    logic            r_perr_int;
    logic [W-1:0]    r_dout;
    logic            r_valid;
    logic            r_perr;
    logic            r_ferr;
    logic            r_busy;

    // Final data bit of the frame is at position W-1; the counter never goes past it.
    logic            w_last;
    assign w_last = (r_cnt == CW'(W - 1));

    // Frame FSM with registered outputs; pulses clear on every edge, state advances only on EN.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_perr_int <= 1'b0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (EN) begin
                case (r_state)
                    S_IDLE: begin
                        if (!DIN) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        // Data arrives LSB first: bit index equals the running count.
                        for (int i = 0; i < W; i++) begin
                            if (r_cnt == CW'(i)) begin
                                r_shreg[i] <= DIN;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        // Even parity: data ones plus parity bit must be even.
                        r_perr_int <= (^r_shreg) ^ DIN;
                        r_state    <= S_STOP;
                    end
                    S_STOP: begin
                        if (DIN) begin
                            r_dout  <= r_shreg;
                            r_perr  <= r_perr_int;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // Word is discarded; DOUT/PERR keep the last good frame.
                            r_ferr  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        // A low line after a bad stop bit is never a new start.
                        if (DIN) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DOUT  = r_dout;
    assign VALID = r_valid;
    assign PERR  = r_perr;
    assign FERR  = r_ferr;
    assign BUSY  = r_busy;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames against serial_frame_rx, checked every
// cycle against a frame-level model plus literal expectations per scenario.
module tb_serial_frame_rx;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         CK  = 1'b0;
    logic         RN  = 1'b0;
    logic         DIN = 1'b1;
    logic         EN  = 1'b0;
    logic [W-1:0] DOUT;
    logic         VALID;
    logic         PERR;
    logic         FERR;
    logic         BUSY;

    int errors = 0;
    int checks = 0;

    serial_frame_rx #(.W(W), .CW(CW)) dut (
        .CK   (CK),
        .RN   (RN),
        .DIN  (DIN),
        .EN   (EN),
        .DOUT (DOUT),
        .VALID(VALID),
        .PERR (PERR),
        .FERR (FERR),
        .BUSY (BUSY)
    );

    always #5 CK = ~CK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // Collects the bits of a frame after the start bit and judges the whole
    // frame once start + W data + parity + stop have been seen.
    bit           m_inframe = 0;
    bit           m_wait    = 0;
    bit           m_bits[$];
    logic [W-1:0] m_dout  = '0;
    bit           m_perr  = 0;
    bit           m_valid = 0;
    bit           m_ferr  = 0;
    bit           m_busy  = 0;

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            m_inframe = 0; m_wait = 0; m_bits.delete();
            m_dout = '0; m_perr = 0; m_valid = 0; m_ferr = 0; m_busy = 0;
        end else begin
            m_valid = 0;
            m_ferr  = 0;
            if (EN) begin
                if (m_wait) begin
                    if (DIN) m_wait = 0;
                end else if (!m_inframe) begin
                    if (!DIN) begin
                        m_inframe = 1;
                        m_bits.delete();
                    end
                end else begin
                    m_bits.push_back(DIN);
                    if (m_bits.size() == W + 2) begin
                        logic [W-1:0] word;
                        int ones;
                        ones = 0;
                        for (int k = 0; k < W; k++) begin
                            word[k] = m_bits[k];
                            ones += int'(m_bits[k]);
                        end
                        ones += int'(m_bits[W]);
                        if (m_bits[W+1]) begin
                            m_dout  = word;
                            m_perr  = (ones % 2) != 0;
                            m_valid = 1;
                        end else begin
                            m_ferr = 1;
                            m_wait = 1;
                        end
                        m_inframe = 0;
                    end
                end
            end
            m_busy = m_inframe || m_wait;
        end
    end

    // ---------------- per-cycle compare ----------------
    int           cyc = 0;
    int           n_valid = 0;
    int           n_ferr  = 0;
    bit           prev_valid = 0;
    int           v_cyc[$];
    logic [W-1:0] v_dout[$];

    always @(negedge CK) begin
        cyc++;
        if (RN) begin
            chk("dout",  32'(DOUT),  32'(m_dout));
            chk("valid", 32'(VALID), 32'(m_valid));
            chk("perr",  32'(PERR),  32'(m_perr));
            chk("ferr",  32'(FERR),  32'(m_ferr));
            chk("busy",  32'(BUSY),  32'(m_busy));
            if (VALID) begin
                chk("valid_width", 32'(prev_valid), 32'd0);
                n_valid++;
                v_cyc.push_back(cyc);
                v_dout.push_back(DOUT);
            end
            if (FERR) n_ferr++;
            prev_valid = VALID;
        end else begin
            prev_valid = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit en, input bit d);
        @(negedge CK);
        #1;
        EN  = en;
        DIN = d;
    endtask

    task automatic send_bit(input bit b, input int gap);
        for (int g = 1; g < gap; g++) tick(1'b0, 1'($urandom_range(0, 1)));
        tick(1'b1, b);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input bit pflip, input bit stop, input int gap);
        send_bit(1'b0, gap);
        for (int k = 0; k < W; k++) send_bit(data[k], gap);
        send_bit((^data) ^ pflip, gap);
        send_bit(stop, gap);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        // Reset state
        #2;
        chk("rst_dout",  32'(DOUT),  32'd0);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_perr",  32'(PERR),  32'd0);
        chk("rst_ferr",  32'(FERR),  32'd0);
        chk("rst_busy",  32'(BUSY),  32'd0);
        @(negedge CK); #2; RN = 1'b1;
        idle(2);

        // Good 0xA5 frame, strobe every cycle
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        idle(2);
        chk("s1_dout",   32'(DOUT), 32'hA5);
        chk("s1_perr",   32'(PERR), 32'd0);
        chk("s1_nvalid", 32'(n_valid), 32'd1);
        chk("s1_nferr",  32'(n_ferr),  32'd0);

        // Parity error still delivers the word, then a good 0x3C
        send_frame(8'hA5, 1'b1, 1'b1, 1);
        idle(2);
        chk("s2_dout", 32'(DOUT), 32'hA5);
        chk("s2_perr", 32'(PERR), 32'd1);
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        idle(2);
        chk("s2b_dout",   32'(DOUT), 32'h3C);
        chk("s2b_perr",   32'(PERR), 32'd0);
        chk("s2b_nvalid", 32'(n_valid), 32'd3);

        // Bad stop bit, line held low, then recovery with 0x55
        send_frame(8'h12, 1'b0, 1'b0, 1);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
        chk("s3_nferr",  32'(n_ferr),  32'd1);
        chk("s3_nvalid", 32'(n_valid), 32'd3);
        chk("s3_dout",   32'(DOUT), 32'h3C);
        chk("s3_busy",   32'(BUSY), 32'd1);
        idle(1);
        send_frame(8'h55, 1'b0, 1'b1, 1);
        idle(2);
        chk("s3b_dout", 32'(DOUT), 32'h55);
        chk("s3b_busy", 32'(BUSY), 32'd0);

        // Sparse strobe with noise on idle-strobe cycles
        send_frame(8'hA5, 1'b0, 1'b1, 3);
        idle(2);
        chk("s4_dout",   32'(DOUT), 32'hA5);
        chk("s4_perr",   32'(PERR), 32'd0);
        chk("s4_nvalid", 32'(n_valid), 32'd5);

        // Asynchronous reset mid-frame
        nv = n_valid;
        send_bit(1'b0, 1);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1);
        @(posedge CK); #3;
        RN = 1'b0;
        #1;
        chk("s5_dout",  32'(DOUT),  32'd0);
        chk("s5_busy",  32'(BUSY),  32'd0);
        chk("s5_perr",  32'(PERR),  32'd0);
        chk("s5_valid", 32'(VALID), 32'd0);
        chk("s5_ferr",  32'(FERR),  32'd0);
        @(negedge CK); #2; RN = 1'b1;
        idle(2);
        chk("s5_noval", 32'(n_valid), 32'(nv));
        send_frame(8'h3C, 1'b0, 1'b1, 1);
        idle(2);
        chk("s5b_dout", 32'(DOUT), 32'h3C);

        // Back-to-back frames, no idle bits between them
        nv = n_valid;
        send_frame(8'h01, 1'b0, 1'b1, 1);
        send_frame(8'hFF, 1'b0, 1'b1, 1);
        idle(2);
        chk("s6_nvalid", 32'(n_valid - nv), 32'd2);
        if (v_cyc.size() >= 2) begin
            chk("s6_gap",    32'(v_cyc[v_cyc.size()-1] - v_cyc[v_cyc.size()-2]), 32'd11);
            chk("s6_first",  32'(v_dout[v_dout.size()-2]), 32'h01);
        end else begin
            chk("s6_pulses", 32'(v_cyc.size()), 32'd2);
        end
        chk("s6_dout", 32'(DOUT), 32'hFF);
        chk("s6_perr", 32'(PERR), 32'd0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
